// File: rtl/sram_arbiter.sv
// -----------------------------------------------------------------------------
// sram_arbiter
//   Two-requester round-robin arbiter in front of a single SRAM core port.
//   A grant registers the winner's command onto sram_* and holds it until the
//   core accepts it (sram_req & sram_ready). The arbiter then spends one cycle
//   in IDLE before it can grant again.
//   Read owners are queued in a small tag FIFO so that in-order read data can
//   be steered back to the requester that issued the read.
//
// Handshake semantics (requester side and SRAM side):
//   A command is transferred on a cycle where valid (mN_req / sram_req) and
//   ready (mN_ready / sram_ready) are both high. The command fields must stay
//   stable while valid is high and ready is low. Read data is a one-cycle
//   pulse (sram_rd_data_vld / mN_rd_data_vld) that has no back-pressure.
//
// Ports
//   a_clk, a_rst_n       clock, asynchronous active-low reset
//   mN_req/rd/addr/be/wr_data  command from requester N (N = 0,1)
//   mN_ready             command of requester N accepted this cycle
//   mN_rd_data_vld/rd_data     read return to requester N
//   sram_req/rd/addr/be/wr_data  registered command to the SRAM core
//   sram_ready, sram_rd_data_vld, sram_rd_data  from the SRAM core
//   err_orphan           sticky: read data arrived with no read outstanding
//   dbg_state            FSM state (0 = IDLE, 1 = BUSY)
// -----------------------------------------------------------------------------
module sram_arbiter #(
   parameter int TAG_DEPTH = 8
) (
   input  logic        a_clk,
   input  logic        a_rst_n,
   // requester 0
   input  logic        m0_req,
   input  logic        m0_rd,
   input  logic [17:0] m0_addr,
   input  logic [1:0]  m0_be,
   input  logic [15:0] m0_wr_data,
   output logic        m0_ready,
   output logic        m0_rd_data_vld,
   output logic [15:0] m0_rd_data,
   // requester 1
   input  logic        m1_req,
   input  logic        m1_rd,
   input  logic [17:0] m1_addr,
   input  logic [1:0]  m1_be,
   input  logic [15:0] m1_wr_data,
   output logic        m1_ready,
   output logic        m1_rd_data_vld,
   output logic [15:0] m1_rd_data,
   // SRAM core
   output logic        sram_req,
   output logic        sram_rd,
   output logic [17:0] sram_addr,
   output logic [1:0]  sram_be,
   output logic [15:0] sram_wr_data,
   input  logic        sram_ready,
   input  logic        sram_rd_data_vld,
   input  logic [15:0] sram_rd_data,
   // status
   output logic        err_orphan,
   output logic        dbg_state
);

   localparam int PW = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;
   localparam logic [PW:0] FULL_CNT = (PW+1)'(TAG_DEPTH);

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_t;

   state_t         state;
   logic           owner;       // requester currently holding sram_req
   logic           last_grant;  // requester whose command was last accepted
   logic [PW-1:0]  wr_ptr;
   logic [PW-1:0]  rd_ptr;
   logic [PW:0]    count;
   logic           tag_mem [TAG_DEPTH];

   logic fifo_full;
   logic fifo_empty;
   logic elig0;
   logic elig1;
   logic grant_sel;
   logic accept;
   logic push;
   logic pop;
   logic head_tag;

   assign fifo_full  = (count == FULL_CNT);
   assign fifo_empty = (count == '0);

   // A read may only be granted if its owner can be queued; writes never
   // need a tag, so they stay grantable while the FIFO is full.
   assign elig0 = m0_req & (~m0_rd | ~fifo_full);
   assign elig1 = m1_req & (~m1_rd | ~fifo_full);

   // On contention the requester not granted last wins; otherwise the sole
   // eligible requester wins (elig1 selects 1 when only m1 is eligible).
   assign grant_sel = (elig0 & elig1) ? ~last_grant : elig1;

   // sram_req is only ever high in BUSY and is forced low by reset, so the
   // ready/valid outputs below are inherently zero while a_rst_n is low.
   assign accept   = sram_req & sram_ready;
   assign push     = accept & sram_rd;
   assign pop      = sram_rd_data_vld & ~fifo_empty;
   assign head_tag = tag_mem[rd_ptr];

   assign m0_ready = accept & (owner == 1'b0);
   assign m1_ready = accept & (owner == 1'b1);

   assign m0_rd_data_vld = pop & (head_tag == 1'b0);
   assign m1_rd_data_vld = pop & (head_tag == 1'b1);
   assign m0_rd_data     = sram_rd_data;
   assign m1_rd_data     = sram_rd_data;

   assign dbg_state = (state == BUSY);

   // Tag storage needs no reset: occupancy is tracked by count/pointers.
   always_ff @(posedge a_clk) begin
      if (push) begin
         tag_mem[wr_ptr] <= owner;
      end
   end

   always_ff @(posedge a_clk or negedge a_rst_n) begin
      if (!a_rst_n) begin
         state        <= IDLE;
         sram_req     <= 1'b0;
         sram_rd      <= 1'b0;
         sram_addr    <= '0;
         sram_be      <= '0;
         sram_wr_data <= '0;
         owner        <= 1'b0;
         last_grant   <= 1'b1;
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         count        <= '0;
         err_orphan   <= 1'b0;
      end else begin
         // tag FIFO bookkeeping; pointers wrap naturally (power-of-two depth)
         if (push) begin
            wr_ptr <= wr_ptr + PW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PW'(1);
         end
         case ({push, pop})
            2'b10:   count <= count + (PW+1)'(1);
            2'b01:   count <= count - (PW+1)'(1);
            default: count <= count;
         endcase

         if (sram_rd_data_vld && fifo_empty) begin
            err_orphan <= 1'b1;
         end

         case (state)
            IDLE: begin
               if (elig0 || elig1) begin
                  state    <= BUSY;
                  sram_req <= 1'b1;
                  owner    <= grant_sel;
                  if (grant_sel) begin
                     sram_rd      <= m1_rd;
                     sram_addr    <= m1_addr;
                     sram_be      <= m1_be;
                     sram_wr_data <= m1_wr_data;
                  end else begin
                     sram_rd      <= m0_rd;
                     sram_addr    <= m0_addr;
                     sram_be      <= m0_be;
                     sram_wr_data <= m0_wr_data;
                  end
               end
            end
            BUSY: begin
               // The owner dropping its request does not cancel the command.
               if (accept) begin
                  state      <= IDLE;
                  sram_req   <= 1'b0;
                  last_grant <= owner;
               end
            end
            default: begin
               state    <= IDLE;
               sram_req <= 1'b0;
            end
         endcase
      end
   end

endmodule
